alu_rr_arbiter: RTL and testbench

Shares one 8-bit ALU between two requesters using round-robin arbitration. Each requester uses a valid/ready handshake to deliver an operation (A, B, ALU_Sel). The block registers the operands, drives its own internal instance of the 8-bit ALU, and registers the result with flags. It returns the result on one valid/ready response channel tagged with the requester ID.

---
 rtl/alu_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end sharing one 8-bit ALU.
// Each operation runs accept -> execute -> respond, with one operation in flight at a time.

module alu8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [2:0] sel_i,
    output logic [7:0] out_o,
    output logic       carry_o
);
    always_comb begin
        out_o   = 8'h00;
        carry_o = 1'b0;
        case (sel_i)
            3'b000:  {carry_o, out_o} = {1'b0, a_i} + {1'b0, b_i};
            3'b001:  out_o = a_i - b_i;
            3'b010:  out_o = a_i & b_i;
            3'b011:  out_o = a_i | b_i;
            3'b100:  out_o = a_i ^ b_i;
            3'b101:  out_o = ~a_i;
            3'b110:  out_o = {a_i[6:0], 1'b0};
            3'b111:  out_o = {1'b0, a_i[7:1]};
            default: out_o = 8'h00;
        endcase
    end
endmodule

module alu_rr_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Req0_Valid,
    output logic       Req0_Ready,
    input  logic [7:0] Req0_A,
    input  logic [7:0] Req0_B,
    input  logic [2:0] Req0_Sel,
    input  logic       Req1_Valid,
    output logic       Req1_Ready,
    input  logic [7:0] Req1_A,
    input  logic [7:0] Req1_B,
    input  logic [2:0] Req1_Sel,
    output logic       Rsp_Valid,
    input  logic       Rsp_Ready,
    output logic [7:0] Rsp_Out,
    output logic       Rsp_Carry,
    output logic       Rsp_Zero,
    output logic       Rsp_Id,
    output logic       Busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        grant_id;
    logic        accept;
    logic        rsp_load;

    logic [7:0]  a_q, b_q;
    logic [2:0]  sel_q;
    logic        id_q;

    logic [7:0]  alu_out;
    logic        alu_carry;

    logic [7:0]  rsp_out_q;
    logic        rsp_carry_q, rsp_zero_q, rsp_id_q;

    // The pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        grant_id   = (Req0_Valid && Req1_Valid) ? ptr_q : Req1_Valid;
        Req0_Ready = (state_q == IDLE) && Req0_Valid && !grant_id;
        Req1_Ready = (state_q == IDLE) && Req1_Valid &&  grant_id;
        accept     = Req0_Ready || Req1_Ready;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rsp_load = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: begin
                rsp_load = 1'b1;
                state_d  = RESP;
            end
            RESP: if (Rsp_Ready) begin
                ptr_d   = ~rsp_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PRIO_INIT;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Operand capture happens only on the request handshake edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= grant_id ? Req1_A   : Req0_A;
            b_q   <= grant_id ? Req1_B   : Req0_B;
            sel_q <= grant_id ? Req1_Sel : Req0_Sel;
            id_q  <= grant_id;
        end
    end

    alu8 u_alu (
        .a_i     (a_q),
        .b_i     (b_q),
        .sel_i   (sel_q),
        .out_o   (alu_out),
        .carry_o (alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_out_q   <= 8'h00;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else if (rsp_load) begin
            rsp_out_q   <= alu_out;
            rsp_carry_q <= alu_carry;
            rsp_zero_q  <= (alu_out == 8'h00);
            rsp_id_q    <= id_q;
        end
    end

    assign Rsp_Valid = (state_q == RESP);
    assign Rsp_Out   = rsp_out_q;
    assign Rsp_Carry = rsp_carry_q;
    assign Rsp_Zero  = rsp_zero_q;
    assign Rsp_Id    = rsp_id_q;
    assign Busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: reset, ADD, round robin, backpressure, opcodes,
// mid-operation reset and back-to-back single-requester traffic.

module tb_alu_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       Req0_Valid, Req0_Ready;
    logic [7:0] Req0_A, Req0_B;
    logic [2:0] Req0_Sel;
    logic       Req1_Valid, Req1_Ready;
    logic [7:0] Req1_A, Req1_B;
    logic [2:0] Req1_Sel;
    logic       Rsp_Valid, Rsp_Ready;
    logic [7:0] Rsp_Out;
    logic       Rsp_Carry, Rsp_Zero, Rsp_Id, Busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    alu_rr_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready),
        .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Sel(Req0_Sel),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready),
        .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Sel(Req1_Sel),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
        .Rsp_Out(Rsp_Out), .Rsp_Carry(Rsp_Carry), .Rsp_Zero(Rsp_Zero),
        .Rsp_Id(Rsp_Id), .Busy(Busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Opcode table: A, B, Sel, expected Out, Carry, Zero.
    logic [7:0] op_a   [7] = '{8'd5,  8'h55, 8'h81, 8'h81, 8'h0F, 8'hF0, 8'hF0};
    logic [7:0] op_b   [7] = '{8'd10, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'h3C, 8'h0F};
    logic [2:0] op_sel [7] = '{3'b001, 3'b100, 3'b110, 3'b111, 3'b101, 3'b010, 3'b011};
    logic [7:0] op_out [7] = '{8'd251, 8'h00, 8'h02, 8'h40, 8'hF0, 8'h30, 8'hFF};
    logic       op_z   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one complete transaction from the given requester and returns what was observed.
    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sel, output logic done, output logic [7:0] out,
                          output logic c, output logic z, output logic rid);
        int k;
        done = 1'b0; out = 8'h00; c = 1'b0; z = 1'b0; rid = 1'b0;
        if (id) begin
            Req1_Valid = 1'b1; Req1_A = a; Req1_B = b; Req1_Sel = sel;
        end else begin
            Req0_Valid = 1'b1; Req0_A = a; Req0_B = b; Req0_Sel = sel;
        end
        #1;
        k = 0;
        while (!(id ? Req1_Ready : Req0_Ready) && k < 10) begin
            tick();
            k++;
        end
        tick();
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        k = 0;
        while (!Rsp_Valid && k < 10) begin
            tick();
            k++;
        end
        if (Rsp_Valid) begin
            done = 1'b1; out = Rsp_Out; c = Rsp_Carry; z = Rsp_Zero; rid = Rsp_Id;
        end
        Rsp_Ready = 1'b1;
        tick();
        Rsp_Ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        Req0_Valid = 1'b0; Req0_A = '0; Req0_B = '0; Req0_Sel = '0;
        Req1_Valid = 1'b0; Req1_A = '0; Req1_B = '0; Req1_Sel = '0;
        Rsp_Ready = 1'b0;
        tick(); tick();
        n_checks++;
        if ({Rsp_Valid, Rsp_Out, Rsp_Carry, Rsp_Zero, Rsp_Id, Busy, Req0_Ready, Req1_Ready} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got V=%b Out=%0h C=%b Z=%b Id=%b Busy=%b R0=%b R1=%b, expected all 0",
                     Rsp_Valid, Rsp_Out, Rsp_Carry, Rsp_Zero, Rsp_Id, Busy, Req0_Ready, Req1_Ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add;
        Req0_Valid = 1'b1; Req0_A = 8'd200; Req0_B = 8'd100; Req0_Sel = 3'b000;
        #1;
        n_checks++;
        if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_accept: got R0=%b R1=%b, expected R0=1 R1=0", Req0_Ready, Req1_Ready);
        end
        tick();
        Req0_Valid = 1'b0;
        n_checks++;
        if (Rsp_Valid !== 1'b0 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL add_exec: got V=%b Busy=%b, expected V=0 Busy=1", Rsp_Valid, Busy);
        end
        tick();
        n_checks++;
        if (Rsp_Valid !== 1'b1 || Rsp_Out !== 8'd44 || Rsp_Carry !== 1'b1 || Rsp_Zero !== 1'b0 || Rsp_Id !== 1'b0) begin
            n_fail++;
            $display("FAIL add_resp: got V=%b Out=%0d C=%b Z=%b Id=%b, expected V=1 Out=44 C=1 Z=0 Id=0",
                     Rsp_Valid, Rsp_Out, Rsp_Carry, Rsp_Zero, Rsp_Id);
        end
        Rsp_Ready = 1'b1;
        tick();
        Rsp_Ready = 1'b0;
        n_checks++;
        if (Rsp_Valid !== 1'b0 || Busy !== 1'b0 || Rsp_Out !== 8'd44) begin
            n_fail++;
            $display("FAIL add_done: got V=%b Busy=%b Out=%0d, expected V=0 Busy=0 Out=44", Rsp_Valid, Busy, Rsp_Out);
        end
    endtask

    task automatic test_round_robin;
        logic       ids[$];
        logic [7:0] outs[$];
        int         cycs[$];
        int         k;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        Req0_Valid = 1'b1; Req0_A = 8'd1; Req0_B = 8'd1; Req0_Sel = 3'b000;
        Req1_Valid = 1'b1; Req1_A = 8'd3; Req1_B = 8'd4; Req1_Sel = 3'b000;
        Rsp_Ready = 1'b1;
        k = 0;
        while (ids.size() < 4 && k < 40) begin
            tick();
            k++;
            if (Rsp_Valid) begin
                ids.push_back(Rsp_Id);
                outs.push_back(Rsp_Out);
                cycs.push_back(cyc);
            end
        end
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        tick();
        Rsp_Ready = 1'b0;
        n_checks++;
        if (ids.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count: got %0d responses, expected 4", ids.size());
        end
        for (int i = 0; i < ids.size(); i++) begin
            n_checks++;
            if (ids[i] !== ((i % 2) == 1) || outs[i] !== ((i % 2) == 1 ? 8'd7 : 8'd2)) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got Id=%b Out=%0d, expected Id=%0d Out=%0d",
                         i, ids[i], outs[i], i % 2, (i % 2) == 1 ? 7 : 2);
            end
            if (i > 0) begin
                n_checks++;
                if (cycs[i] - cycs[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL rr_cadence[%0d]: got %0d cycles, expected 3", i, cycs[i] - cycs[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int k;
        Rsp_Ready = 1'b0;
        Req1_Valid = 1'b1; Req1_A = 8'h80; Req1_B = 8'h80; Req1_Sel = 3'b000;
        #1;
        n_checks++;
        if (Req1_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: got R1=%b, expected 1", Req1_Ready);
        end
        tick();
        Req1_Valid = 1'b0;
        k = 0;
        while (!Rsp_Valid && k < 10) begin
            tick();
            k++;
        end
        Req0_Valid = 1'b1; Req0_A = 8'd9; Req0_B = 8'd9; Req0_Sel = 3'b000;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (Rsp_Valid !== 1'b1 || Rsp_Out !== 8'h00 || Rsp_Carry !== 1'b1 || Rsp_Zero !== 1'b1 ||
                Rsp_Id !== 1'b1 || Req0_Ready !== 1'b0 || Req1_Ready !== 1'b0 || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got V=%b Out=%0h C=%b Z=%b Id=%b R0=%b R1=%b Busy=%b, expected V=1 Out=0 C=1 Z=1 Id=1 R0=0 R1=0 Busy=1",
                         i, Rsp_Valid, Rsp_Out, Rsp_Carry, Rsp_Zero, Rsp_Id, Req0_Ready, Req1_Ready, Busy);
            end
            tick();
        end
        Rsp_Ready = 1'b1;
        tick();
        Rsp_Ready = 1'b0;
        n_checks++;
        if (Rsp_Valid !== 1'b0 || Busy !== 1'b0 || Req0_Ready !== 1'b1 || Rsp_Id !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got V=%b Busy=%b R0=%b Id=%b, expected V=0 Busy=0 R0=1 Id=1",
                     Rsp_Valid, Busy, Req0_Ready, Rsp_Id);
        end
        Req0_Valid = 1'b0;
    endtask

    task automatic test_opcodes;
        logic       done, c, z, rid;
        logic [7:0] out;
        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, op_a[i], op_b[i], op_sel[i], done, out, c, z, rid);
            n_checks++;
            if (done !== 1'b1 || out !== op_out[i] || c !== 1'b0 || z !== op_z[i] || rid !== 1'b0) begin
                n_fail++;
                $display("FAIL opcode[sel=%b]: got done=%b Out=%0h C=%b Z=%b Id=%b, expected done=1 Out=%0h C=0 Z=%b Id=0",
                         op_sel[i], done, out, c, z, rid, op_out[i], op_z[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        logic       done, c, z, rid;
        logic [7:0] out;
        int         k;
        // Leave the pointer on requester 1 so a reset back to PRIO_INIT is observable.
        run_op(1'b0, 8'd1, 8'd2, 3'b000, done, out, c, z, rid);
        n_checks++;
        if (done !== 1'b1 || out !== 8'd3 || rid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre: got done=%b Out=%0d Id=%b, expected done=1 Out=3 Id=0", done, out, rid);
        end
        Req0_Valid = 1'b1; Req0_A = 8'd9; Req0_B = 8'd9; Req0_Sel = 3'b000;
        tick();
        Req0_Valid = 1'b0;
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_exec: got Busy=%b, expected 1", Busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Rsp_Valid !== 1'b0 || Rsp_Out !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: got Busy=%b V=%b Out=%0h, expected Busy=0 V=0 Out=0", Busy, Rsp_Valid, Rsp_Out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (Rsp_Valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_rsp[%0d]: got V=%b, expected 0", i, Rsp_Valid);
            end
        end
        rst_n = 1'b1;
        tick();
        Req0_Valid = 1'b1; Req0_A = 8'd20; Req0_B = 8'd22; Req0_Sel = 3'b000;
        Req1_Valid = 1'b1; Req1_A = 8'd1;  Req1_B = 8'd1;  Req1_Sel = 3'b000;
        #1;
        n_checks++;
        if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ptr: got R0=%b R1=%b, expected R0=1 R1=0", Req0_Ready, Req1_Ready);
        end
        tick();
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        k = 0;
        while (!Rsp_Valid && k < 10) begin
            tick();
            k++;
        end
        n_checks++;
        if (Rsp_Valid !== 1'b1 || Rsp_Id !== 1'b0 || Rsp_Out !== 8'd42) begin
            n_fail++;
            $display("FAIL mid_after: got V=%b Id=%b Out=%0d, expected V=1 Id=0 Out=42", Rsp_Valid, Rsp_Id, Rsp_Out);
        end
        Rsp_Ready = 1'b1;
        tick();
        Rsp_Ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int hs, k;
        int cycs[$];
        logic ids[$];
        logic [7:0] outs[$];
        Req1_Valid = 1'b1; Req1_A = 8'd10; Req1_B = 8'd3; Req1_Sel = 3'b001;
        Rsp_Ready = 1'b1;
        #1;
        hs = (Req1_Ready === 1'b1) ? 1 : 0;
        k = 0;
        while (ids.size() < 3 && k < 40) begin
            tick();
            k++;
            if (hs == 3) Req1_Valid = 1'b0;
            if (Rsp_Valid) begin
                ids.push_back(Rsp_Id);
                outs.push_back(Rsp_Out);
                cycs.push_back(cyc);
            end
            #1;
            if (Req1_Valid && Req1_Ready && hs < 3) hs++;
        end
        Req1_Valid = 1'b0;
        tick();
        Rsp_Ready = 1'b0;
        n_checks++;
        if (ids.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses, expected 3", ids.size());
        end
        for (int i = 0; i < ids.size(); i++) begin
            n_checks++;
            if (ids[i] !== 1'b1 || outs[i] !== 8'd7) begin
                n_fail++;
                $display("FAIL b2b_rsp[%0d]: got Id=%b Out=%0d, expected Id=1 Out=7", i, ids[i], outs[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (cycs[i] - cycs[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL b2b_cadence[%0d]: got %0d cycles, expected 3", i, cycs[i] - cycs[i-1]);
                end
            end
        end
        n_checks++;
        if (Busy !== 1'b0 || Rsp_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got Busy=%b V=%b, expected Busy=0 V=0", Busy, Rsp_Valid);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_backpressure();
        test_opcodes();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
